// File: rtl/spi_byte_streamer.sv
// spi_byte_streamer
//   Byte-stream front end for spi_master_controller. Outgoing bytes are queued in a TX FIFO and
//   each one is launched as a single-byte controller transaction over the start/busy handshake.
//   Received bytes are queued in an RX FIFO (first-word fall-through) unless the launch was marked
//   as write-only with rx_discard.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset (shared with the controller)
//   tx_data/valid/ready    TX push interface (ready = TX FIFO not full)
//   rx_data/valid/ready    RX pop interface (data = FIFO head, valid = not empty)
//   rx_discard             sampled at launch; drops that transfer's received byte
//   tx_level, rx_level     FIFO occupancies, 0..DEPTH
//   idle                   FSM idle and nothing queued for transmit
//   spi_start/spi_data_in  to controller start/data_in
//   spi_busy/spi_data_out  from controller busy/data_out
module spi_byte_streamer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic          rx_discard,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic          idle,
    output logic          spi_start,
    output logic [7:0]    spi_data_in,
    input  logic          spi_busy,
    input  logic [7:0]    spi_data_out
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StCapture} state_e;

    state_e state_q, state_d;
    logic   drop_q;
    logic [7:0] cap_q;
    logic [7:0] data_in_q;
    logic   launch, cap_en, rx_push_req;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [LW-1:0] tx_cnt_q;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt_q == LW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = tx_valid && !tx_full;
    assign tx_pop   = launch;  // launch is only taken when the FIFO is non-empty

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            if (tx_push && !tx_pop) begin
                tx_cnt_q <= tx_cnt_q + LW'(1);
            end else if (!tx_push && tx_pop) begin
                tx_cnt_q <= tx_cnt_q - LW'(1);
            end
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [LW-1:0] rx_cnt_q;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_cnt_q == LW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_push  = rx_push_req && !rx_full;
    assign rx_pop   = rx_ready && !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= cap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
            if (rx_push && !rx_pop) begin
                rx_cnt_q <= rx_cnt_q + LW'(1);
            end else if (!rx_push && rx_pop) begin
                rx_cnt_q <= rx_cnt_q - LW'(1);
            end
        end
    end

    // ---------------------------------------------------------------- transfer FSM
    // A transfer that will push into RX holds a reserved slot from launch until CAPTURE, so the
    // space check counts it and RX can never overflow.
    logic rx_reserved;
    logic rx_space_ok;

    assign rx_reserved = (state_q != StIdle) && !drop_q;
    assign rx_space_ok = (rx_cnt_q + LW'(rx_reserved)) < LW'(DEPTH);

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        cap_en      = 1'b0;
        rx_push_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!tx_empty && (rx_discard || rx_space_ok)) begin
                    launch  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // The controller only samples start on its SCK tick; hold until it answers.
                if (spi_busy) state_d = StXfer;
            end
            StXfer: begin
                // busy and data_out change on the same edge, so data_out is valid now.
                if (!spi_busy) begin
                    cap_en  = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rx_push_req = !drop_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            drop_q    <= 1'b0;
            cap_q     <= '0;
            data_in_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                data_in_q <= tx_mem[tx_rd_q];
                drop_q    <= rx_discard;
            end
            if (cap_en) begin
                cap_q <= spi_data_out;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign tx_ready    = !tx_full;
    assign tx_level    = tx_cnt_q;
    assign rx_valid    = !rx_empty;
    assign rx_level    = rx_cnt_q;
    // Gate the head so rx_data reads zero whenever the FIFO is empty, including after reset.
    assign rx_data     = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
    assign idle        = (state_q == StIdle) && tx_empty;
    assign spi_start   = (state_q == StReq);
    assign spi_data_in = data_in_q;

endmodule

// File: tb/tb_spi_byte_streamer.sv
// Self-checking bench for spi_byte_streamer. The SPI controller is replaced by a behavioural
// model: it samples start once per SCK tick period, stays busy for a random length, and answers
// each byte with a fixed function of the byte sent. Expected data comes from queues of what was
// pushed.
module tb_spi_byte_streamer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned DIV   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_discard;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          idle;
    logic          spi_start;
    logic [7:0]    spi_data_in;
    logic          m_busy;
    logic [7:0]    m_dout;

    always #5 clk = ~clk;

    spi_byte_streamer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_discard  (rx_discard),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .idle        (idle),
        .spi_start   (spi_start),
        .spi_data_in (spi_data_in),
        .spi_busy    (m_busy),
        .spi_data_out(m_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sent_q[$];  // bytes the controller must see, in order
    logic [7:0] exp_q[$];   // replies expected in RX during the random phase
    logic       stall = 1'b0;
    int         xfers = 0;
    int         tick  = 0;
    int         remain = 0;
    logic [7:0] cur   = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reply(input logic [7:0] b);
        return {b[3:0], b[7:4]} ^ 8'h5A;
    endfunction

    // Controller model.
    initial begin
        m_busy = 1'b0;
        m_dout = 8'h00;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy <= 1'b0;
                m_dout <= 8'h00;
                tick   <= 0;
            end else begin
                tick <= (tick == 2 * DIV - 1) ? 0 : tick + 1;
                if (!m_busy) begin
                    if (tick == 0 && spi_start && !stall) begin
                        m_busy <= 1'b1;
                        remain <= $urandom_range(4, 20);
                        cur    <= spi_data_in;
                        xfers  <= xfers + 1;
                        check_eq("mosi_pending", 32'(sent_q.size() != 0), 1);
                        if (sent_q.size() != 0) check_eq("mosi_byte", spi_data_in, sent_q.pop_front());
                    end
                end else if (remain == 0) begin
                    m_busy <= 1'b0;
                    m_dout <= reply(cur);
                end else begin
                    remain <= remain - 1;
                    m_dout <= 8'($urandom);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sent_q.delete();
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq("push_timeout", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        sent_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(idle && !m_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq(tag, 32'(idle && !m_busy), 1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!rx_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        reset      = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        rx_discard = 1'b0;
        do_reset();

        // Reset values
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_tx_level", tx_level, 0);
        check_eq("rst_rx_level", rx_level, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_spi_start", spi_start, 0);
        check_eq("rst_spi_data_in", spi_data_in, 0);

        // Single byte with handshake timing
        base = xfers;
        push_byte(8'hA5);
        check_eq("a5_level_after_push", tx_level, 1);
        check_eq("a5_start_not_yet", spi_start, 0);
        @(negedge clk);
        check_eq("a5_start_lat", spi_start, 1);
        check_eq("a5_data_in", spi_data_in, 8'hA5);
        check_eq("a5_tx_popped", tx_level, 0);
        n = 0;
        while (!m_busy && n < 50) begin @(negedge clk); n++; end
        check_eq("a5_busy_seen", m_busy, 1);
        check_eq("a5_start_hold", spi_start, 1);
        @(negedge clk);
        check_eq("a5_start_drop", spi_start, 0);
        n = 0;
        while (m_busy && n < 50) begin @(negedge clk); n++; end
        check_eq("a5_rx_lat0", rx_valid, 0);
        @(negedge clk);
        check_eq("a5_rx_lat1", rx_valid, 0);
        @(negedge clk);
        check_eq("a5_rx_lat2", rx_valid, 1);
        check_eq("a5_rx_data", rx_data, reply(8'hA5));
        check_eq("a5_idle", idle, 1);
        check_eq("a5_xfers", xfers - base, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("a5_popped", rx_valid, 0);

        // Reset while holding start in REQ
        stall = 1'b1;
        push_byte(8'h3C);
        repeat (4) @(negedge clk);
        check_eq("req_start_held", spi_start, 1);
        do_reset();
        stall = 1'b0;
        check_eq("req_rst_start", spi_start, 0);
        check_eq("req_rst_tx_level", tx_level, 0);
        check_eq("req_rst_rx_level", rx_level, 0);
        check_eq("req_rst_idle", idle, 1);
        check_eq("req_rst_tx_ready", tx_ready, 1);

        // RX back-pressure: 6 bytes, only DEPTH transfers may run
        base = xfers;
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        repeat (300) @(negedge clk);
        check_eq("bp_xfers", xfers - base, 4);
        check_eq("bp_tx_level", tx_level, 2);
        check_eq("bp_rx_level", rx_level, 4);
        check_eq("bp_start_low", spi_start, 0);
        pop_check("bp_rx0", reply(8'h01));
        n = 0;
        while (xfers - base < 5 && n < 200) begin @(negedge clk); n++; end
        check_eq("bp_fifth_xfer", xfers - base, 5);
        for (int i = 2; i <= 6; i++) pop_check("bp_rx", reply(8'(i)));
        wait_idle("bp_idle_timeout");
        check_eq("bp_rx_empty", rx_level, 0);

        // Discard: only the reply to 0x00 is kept
        rx_discard = 1'b1;
        push_byte(8'h9F);
        wait_idle("disc_idle_timeout");
        rx_discard = 1'b0;
        push_byte(8'h00);
        wait_idle("disc_idle_timeout2");
        repeat (3) @(negedge clk);
        check_eq("disc_rx_level", rx_level, 1);
        check_eq("disc_rx_data", rx_data, reply(8'h00));
        pop_check("disc_pop", reply(8'h00));

        // TX full while the controller stalls in REQ
        base  = xfers;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data  = 8'h40 + 8'(i);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        // First byte is launched on the second edge, bytes 1..4 fill the FIFO, the sixth is dropped.
        for (int i = 0; i < 5; i++) sent_q.push_back(8'h40 + 8'(i));
        check_eq("full_tx_level", tx_level, 4);
        check_eq("full_tx_ready", tx_ready, 0);
        check_eq("full_start", spi_start, 1);
        check_eq("full_head", spi_data_in, 8'h40);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) pop_check("full_rx", reply(8'h40 + 8'(i)));
        wait_idle("full_idle_timeout");
        check_eq("full_xfers", xfers - base, 5);

        // Randomized bursts with random RX pops
        for (int burst = 0; burst < 8; burst++) begin
            logic prod_done;
            logic disc;
            prod_done  = 1'b0;
            disc       = ($urandom_range(0, 3) == 0);
            rx_discard = disc;
            fork
                begin
                    for (int i = 0; i < 10; i++) begin
                        logic [7:0] b;
                        b = 8'($urandom);
                        if (!disc) exp_q.push_back(reply(b));
                        push_byte(b);
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                    prod_done = 1'b1;
                end
                begin
                    int guard = 0;
                    while (!(prod_done && exp_q.size() == 0) && guard < 5000) begin
                        if (rx_valid && ($urandom_range(0, 1) == 1)) begin
                            if (exp_q.size() == 0) begin
                                check_eq("rand_rx_extra", rx_valid, 0);
                                rx_ready = 1'b0;
                            end else begin
                                check_eq("rand_rx", rx_data, exp_q.pop_front());
                                rx_ready = 1'b1;
                            end
                        end else begin
                            rx_ready = 1'b0;
                        end
                        @(negedge clk);
                        guard++;
                    end
                    rx_ready = 1'b0;
                    if (guard >= 5000) check_eq("rand_timeout", exp_q.size(), 0);
                end
            join
            wait_idle("rand_idle_timeout");
            repeat (3) @(negedge clk);
            check_eq("rand_rx_drained", rx_level, 0);
        end
        rx_discard = 1'b0;
        check_eq("all_sent", sent_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_byte_streamer.md
# spi_byte_streamer

Byte-stream front end for `spi_master_controller`, placed directly upstream of it. It buffers outgoing bytes in a TX FIFO and launches one single-byte controller transaction per entry using the controller's `start`/`busy` handshake. Each received byte is collected into an RX FIFO. Firmware-facing logic can push and pop whole byte sequences without tracking per-byte SPI timing.

## Interface
- `DEPTH`, default 16: entries per FIFO (TX and RX each); power of two, ≥ 2.
- `LW`, default `$clog2(DEPTH)+1`: width of the level outputs (derived, not overridden).

Ports:
- `clk` in 1: system clock; same clock as the SPI controller.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: push request for `tx_data`.
- `tx_ready` out 1: TX FIFO not full.
- `rx_data` out 8: head of the RX FIFO (first-word fall-through).
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: pop request for the RX head.
- `rx_discard` in 1: when high at launch, the received byte for that transfer is dropped (write-only traffic).
- `tx_level` out LW: TX occupancy, 0..DEPTH.
- `rx_level` out LW: RX occupancy, 0..DEPTH.
- `idle` out 1: FSM in IDLE and TX FIFO empty.
- `spi_start` out 1: to controller `start`.
- `spi_data_in` out 8: to controller `data_in`.
- `spi_busy` in 1: from controller `busy`.
- `spi_data_out` in 8: from controller `data_out`.

## Operation
FIFOs (both identical):
- Circular buffer with `DEPTH` entries and read/write pointers.
- Level counter of width LW.
- A push occurs when valid and not full.
- A pop occurs when ready and not empty.
- Simultaneous push and pop are both performed; the level is unchanged.
- A push while full is ignored and does not corrupt data.
- A pop while empty is ignored.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, REQ, XFER, CAPTURE.
- IDLE → REQ when the TX FIFO is non-empty and (`rx_discard` = 1 or RX level + pending < DEPTH).
  - On this transition: pop the TX head into `spi_data_in`.
  - Latch `rx_discard` into `drop_q`.
  - Assert `spi_start`.
  - A reserved RX slot guarantees that RX can never overflow.
- REQ: hold `spi_start` = 1 and `spi_data_in` stable until `spi_busy` = 1 is sampled. Then go to XFER with `spi_start` = 0.
  - The controller samples `start` only on its internal SCK tick, so REQ can last up to 2×CLK_DIVIDER cycles.
- XFER: wait for `spi_busy` = 0. The controller updates `busy` and `data_out` on the same edge, so `spi_data_out` is valid in the cycle `spi_busy` is first seen low. Capture it into `cap_q` and go to CAPTURE.
- CAPTURE: if `drop_q` = 0, push `cap_q` into RX. The slot is guaranteed free because it was reserved at launch. Go to IDLE.
- A firmware `rx_ready` pop in the same cycle is allowed: push and pop are both performed.
- The TX FIFO accepts pushes in every state, including mid-transfer.
- Byte order is strict FIFO. The Nth RX byte corresponds to the Nth non-discarded TX byte.
- `spi_data_in` changes only on the IDLE → REQ transition.

Reset:
- All outputs reset: `tx_ready` = 1, `rx_valid` = 0, `rx_data` = 0, levels = 0, `idle` = 1, `spi_start` = 0, `spi_data_in` = 0, state = IDLE.
- Both FIFOs are emptied.
- Reset mid-transfer abandons the byte without pushing it.
- The controller shares `reset`, so both sides return to idle together.

## Timing
- TX push to `spi_start` high: 1 cycle (registered) when IDLE with space available.
- `spi_busy` rising to `spi_start` low: 1 cycle.
- `spi_busy` falling to `rx_valid`: 2 cycles (capture, then push).
- Back-to-back bytes: the next launch occurs in the cycle after CAPTURE, i.e. 3 cycles after `spi_busy` falls, plus the controller's tick alignment.
- `rx_data` and `rx_valid` are combinational from FIFO state; there is no extra latency after a push.
- `tx_ready` and `rx_valid` update the cycle after the push or pop edge.

## Test plan
- Reset with `spi_start` high in REQ:
  - Required: next cycle `spi_start` = 0, levels = 0, `idle` = 1, `tx_ready` = 1.
- Single byte, bench pairs the real controller (CLK_DIVIDER = 2) with MISO looped from MOSI:
  - Push 0xA5.
  - Required: exactly one CS-low frame of 8 SCK rising edges; MOSI = 10100101, MSB first.
  - Required: `rx_data` = 0xA5 with `rx_valid` = 1; `idle` = 1 afterwards.
- Stream of 0x01..0x05 pushed back-to-back:
  - Required: five transactions in order; RX pops return 0x01..0x05; `tx_level` peaks at 5 (or 4 if the first byte is popped immediately).
- RX back-pressure, DEPTH = 4, `rx_ready` = 0:
  - Push 6 bytes.
  - Required: exactly 4 transfers occur; then FSM stays IDLE with `tx_level` = 2 and `rx_level` = 4.
  - Pop one RX byte. Required: the 5th transfer starts.
- `rx_discard` = 1 while pushing 0x9F, then 0 for 0x00:
  - Required: only the reply to 0x00 appears in RX; `rx_level` = 1.
- TX full, DEPTH = 4, controller stalled with `spi_busy` held low by the model so it stays in REQ:
  - Push 6 bytes.
  - Required: `tx_ready` = 0 once the level reaches 4; extra pushes are ignored; the head byte is the first one pushed.
